// File: rtl/instruction_fetch_unit.sv
// Front end of the single-issue core: owns the PC, addresses instruction memory
// and registers the returned word into IF/ID with stall, redirect and flush handling.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter logic [31:0] PC_STEP   = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        flush,
  output logic [31:0] read_address,
  input  logic [31:0] instruction_out,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        misaligned_redirect,
  output logic [31:0] fetch_count
);

  localparam logic [0:0] BOOT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  // Redirect beats stall beats sequential fetch; BOOT spends the reset-release edge idle.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    if_id_pc_d       = if_id_pc_q;
    if_id_pc_plus4_d = if_id_pc_plus4_q;
    if_id_instr_d    = if_id_instr_q;
    if_id_valid_d    = if_id_valid_q;
    misaligned_d     = 1'b0;
    fetch_count_d    = fetch_count_q;

    if (state_q == BOOT) begin
      state_d = RUN;
    end else if (redirect) begin
      pc_d          = {redirect_target[31:2], 2'b00};
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
      misaligned_d  = (redirect_target[1:0] != 2'b00);
    end else if (stall) begin
      if (flush) begin
        if_id_instr_d = NOP_INSTR;
        if_id_valid_d = 1'b0;
      end
    end else begin
      pc_d             = pc_q + PC_STEP;
      if_id_pc_d       = pc_q;
      if_id_pc_plus4_d = pc_q + PC_STEP;
      if_id_instr_d    = flush ? NOP_INSTR : instruction_out;
      if_id_valid_d    = ~flush;
      if (!flush) begin
        fetch_count_d = fetch_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= BOOT;
      pc_q             <= RESET_PC;
      if_id_pc_q       <= RESET_PC;
      if_id_pc_plus4_q <= RESET_PC + PC_STEP;
      if_id_instr_q    <= NOP_INSTR;
      if_id_valid_q    <= 1'b0;
      misaligned_q     <= 1'b0;
      fetch_count_q    <= 32'd0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      if_id_pc_q       <= if_id_pc_d;
      if_id_pc_plus4_q <= if_id_pc_plus4_d;
      if_id_instr_q    <= if_id_instr_d;
      if_id_valid_q    <= if_id_valid_d;
      misaligned_q     <= misaligned_d;
      fetch_count_q    <= fetch_count_d;
    end
  end

  assign read_address        = pc_q;
  assign if_id_pc            = if_id_pc_q;
  assign if_id_pc_plus4      = if_id_pc_plus4_q;
  assign if_id_instr         = if_id_instr_q;
  assign if_id_valid         = if_id_valid_q;
  assign misaligned_redirect = misaligned_q;
  assign fetch_count         = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: hand-derived vector table fed through an
// expected-result queue, plus hand-written reset and PC-wrap sequences.
module tb_instruction_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic        stall;
      logic        flush;
      logic        redirect;
      logic [31:0] target;
      logic [31:0] expAddr;
      logic [31:0] expPc;
      logic [31:0] expPc4;
      logic [31:0] expInstr;
      logic        expValid;
      logic        expMis;
      logic [31:0] expCount;
   } vector_t;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirectTarget;
   logic        flush;
   logic [31:0] readAddress;
   logic [31:0] instructionOut;
   logic [31:0] ifIdPc;
   logic [31:0] ifIdPcPlus4;
   logic [31:0] ifIdInstr;
   logic        ifIdValid;
   logic        misalignedRedirect;
   logic [31:0] fetchCount;

   int checkCount = 0;
   int passCount  = 0;
   vector_t vectorTable[$];
   vector_t expectQueue[$];

   // Instruction memory stand-in: each address returns a distinct word.
   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return addr ^ 32'h5A5A_0000;
   endfunction

   function automatic vector_t mk(input logic st, input logic fl, input logic rd,
                                  input logic [31:0] tgt, input logic [31:0] ea,
                                  input logic [31:0] ep, input logic [31:0] ep4,
                                  input logic [31:0] ei, input logic ev,
                                  input logic em, input logic [31:0] ec);
      vector_t v;
      v.stall = st; v.flush = fl; v.redirect = rd; v.target = tgt;
      v.expAddr = ea; v.expPc = ep; v.expPc4 = ep4; v.expInstr = ei;
      v.expValid = ev; v.expMis = em; v.expCount = ec;
      return v;
   endfunction

   assign instructionOut = memWord(readAddress);

   instruction_fetch_unit dut (
      .clk                 (clk),
      .rst                 (rst),
      .stall               (stall),
      .redirect            (redirect),
      .redirect_target     (redirectTarget),
      .flush               (flush),
      .read_address        (readAddress),
      .instruction_out     (instructionOut),
      .if_id_pc            (ifIdPc),
      .if_id_pc_plus4      (ifIdPcPlus4),
      .if_id_instr         (ifIdInstr),
      .if_id_valid         (ifIdValid),
      .misaligned_redirect (misalignedRedirect),
      .fetch_count         (fetchCount)
   );

   // Free-running clock with rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic compareField(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one vector's inputs and queue the result it should produce.
   task automatic applyStimulus(input vector_t v);
      stall          = v.stall;
      flush          = v.flush;
      redirect       = v.redirect;
      redirectTarget = v.target;
      expectQueue.push_back(v);
   endtask

   // Pop the oldest expectation and compare every observable output against it.
   task automatic checkOutput();
      vector_t e;
      if (expectQueue.size() == 0) begin
         checkCount++;
         $display("[TB] FAIL scoreboard: got empty queue expected an entry at %0t", $time);
         return;
      end
      e = expectQueue.pop_front();
      compareField("read_address", readAddress, e.expAddr);
      compareField("if_id_pc", ifIdPc, e.expPc);
      compareField("if_id_pc_plus4", ifIdPcPlus4, e.expPc4);
      compareField("if_id_instr", ifIdInstr, e.expInstr);
      compareField("if_id_valid", {31'd0, ifIdValid}, {31'd0, e.expValid});
      compareField("misaligned_redirect", {31'd0, misalignedRedirect}, {31'd0, e.expMis});
      compareField("fetch_count", fetchCount, e.expCount);
   endtask

   task automatic runVector(input vector_t v);
      applyStimulus(v);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   initial begin
      vector_t resetState;
      resetState = mk(0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd4, NOP, 0, 0, 32'd0);

      rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirectTarget = 32'd0;

      //                st fl rd target         addr          ifPc          ifPc4         instr                    v  m  count
      vectorTable.push_back(mk(0, 0, 0, 32'd0,          32'd0,        32'd0,        32'd4,        NOP,                     0, 0, 32'd0));
      vectorTable.push_back(mk(0, 0, 0, 32'd0,          32'd4,        32'd0,        32'd4,        memWord(32'd0),          1, 0, 32'd1));
      vectorTable.push_back(mk(0, 0, 0, 32'd0,          32'd8,        32'd4,        32'd8,        memWord(32'd4),          1, 0, 32'd2));
      vectorTable.push_back(mk(1, 0, 0, 32'd0,          32'd8,        32'd4,        32'd8,        memWord(32'd4),          1, 0, 32'd2));
      vectorTable.push_back(mk(1, 0, 0, 32'd0,          32'd8,        32'd4,        32'd8,        memWord(32'd4),          1, 0, 32'd2));
      vectorTable.push_back(mk(1, 0, 0, 32'd0,          32'd8,        32'd4,        32'd8,        memWord(32'd4),          1, 0, 32'd2));
      vectorTable.push_back(mk(0, 0, 0, 32'd0,          32'd12,       32'd8,        32'd12,       memWord(32'd8),          1, 0, 32'd3));
      vectorTable.push_back(mk(0, 0, 1, 32'd40,         32'd40,       32'd8,        32'd12,       NOP,                     0, 0, 32'd3));
      vectorTable.push_back(mk(0, 0, 0, 32'd0,          32'd44,       32'd40,       32'd44,       memWord(32'd40),         1, 0, 32'd4));
      vectorTable.push_back(mk(1, 0, 1, 32'd72,         32'd72,       32'd40,       32'd44,       NOP,                     0, 0, 32'd4));
      vectorTable.push_back(mk(0, 0, 0, 32'd0,          32'd76,       32'd72,       32'd76,       memWord(32'd72),         1, 0, 32'd5));
      vectorTable.push_back(mk(0, 0, 1, 32'd94,         32'd92,       32'd72,       32'd76,       NOP,                     0, 1, 32'd5));
      vectorTable.push_back(mk(0, 0, 0, 32'd0,          32'd96,       32'd92,       32'd96,       memWord(32'd92),         1, 0, 32'd6));
      vectorTable.push_back(mk(0, 0, 1, 32'd102,        32'd100,      32'd92,       32'd96,       NOP,                     0, 1, 32'd6));
      vectorTable.push_back(mk(0, 0, 0, 32'd0,          32'd104,      32'd100,      32'd104,      memWord(32'd100),        1, 0, 32'd7));
      vectorTable.push_back(mk(0, 0, 1, 32'd110,        32'd108,      32'd100,      32'd104,      NOP,                     0, 1, 32'd7));
      vectorTable.push_back(mk(0, 0, 0, 32'd0,          32'd112,      32'd108,      32'd112,      memWord(32'd108),        1, 0, 32'd8));
      vectorTable.push_back(mk(0, 0, 1, 32'd16,         32'd16,       32'd108,      32'd112,      NOP,                     0, 0, 32'd8));
      vectorTable.push_back(mk(0, 1, 0, 32'd0,          32'd20,       32'd16,       32'd20,       NOP,                     0, 0, 32'd8));
      vectorTable.push_back(mk(0, 0, 0, 32'd0,          32'd24,       32'd20,       32'd24,       memWord(32'd20),         1, 0, 32'd9));
      vectorTable.push_back(mk(1, 1, 0, 32'd0,          32'd24,       32'd20,       32'd24,       NOP,                     0, 0, 32'd9));
      vectorTable.push_back(mk(0, 0, 0, 32'd0,          32'd28,       32'd24,       32'd28,       memWord(32'd24),         1, 0, 32'd10));
      vectorTable.push_back(mk(0, 0, 1, 32'd80,         32'd80,       32'd24,       32'd28,       NOP,                     0, 0, 32'd10));
      vectorTable.push_back(mk(0, 0, 0, 32'd0,          32'd84,       32'd80,       32'd84,       memWord(32'd80),         1, 0, 32'd11));

      // Reset held for two edges, then released just after an edge.
      repeat (2) @(posedge clk);
      #1;
      expectQueue.push_back(resetState);
      checkOutput();
      rst = 1'b0;

      foreach (vectorTable[i]) begin
         runVector(vectorTable[i]);
      end

      // Asynchronous reset mid-cycle while pc = 84, observed before the next edge.
      #3;
      rst = 1'b1;
      #1;
      expectQueue.push_back(resetState);
      checkOutput();
      @(posedge clk);
      #1;
      rst = 1'b0;

      // BOOT edge after release, then PC wrap from the top of the address space.
      runVector(mk(0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd4, NOP, 0, 0, 32'd0));
      runVector(mk(0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'd0, 32'd4, NOP, 0, 0, 32'd0));
      runVector(mk(0, 0, 0, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd0, memWord(32'hFFFF_FFFC), 1, 0, 32'd1));
      runVector(mk(0, 0, 0, 32'd0, 32'd4, 32'd0, 32'd4, memWord(32'd0), 1, 0, 32'd2));

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
